intersection_phase_scheduler: RTL and testbench
===============================================

Name: intersection_phase_scheduler

Overview:
- Demand-driven phase scheduler for the four-road intersection (roads P1..P4 plus pedestrian crossing PL).
- Latches vehicle-detector and pedestrian-button requests, grants phases round-robin, and times green/yellow/all-red/walk intervals against a shared timebase tick.
- Drives the same lamp encodings as the fixed-cycle light controller and replaces its free-running sequence with an arbitrated one.
- RECALL mode reproduces the fixed P1→P2→P3→P4→PL cycle.

Parameters:
- TIMER_W, 8, width of duration inputs and the interval timer.
- CLEAR_TICKS, 2, all-red clearance length in ticks (≥1).
- RECALL, 0, 1 = treat all five requests as permanently asserted.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  timebase enable, one clk wide; all durations count ticks
- veh_req  in  4  level/pulse detector per road, bit0=P1 … bit3=P4
- ped_req  in  1  pedestrian button
- green_time  in  TIMER_W  green duration in ticks
- yellow_time  in  TIMER_W  yellow duration in ticks
- walk_time  in  TIMER_W  pedestrian walk duration in ticks
- p1, p2, p3, p4  out  5 each  road lamp code
- pl  out  4  pedestrian lamp code
- active_phase  out  3  0..3 = P1..P4, 4 = PL, 7 = none
- pending  out  5  latched requests {PL,P4,P3,P2,P1}

Behaviour:
- Lamp codes: GREEN=5'b10011, YELLOW=5'b01000, RED=5'b00100; PED_GO=4'b0000, PED_STOP=4'b1111.
- Reset (asynchronous assert, synchronous deassert by the system): p1..p4=RED, pl=PED_STOP, active_phase=7, pending=0, rr pointer=0, state=ALLRED, timer=CLEAR_TICKS.
- States: ALLRED, GREEN, YELLOW, WALK. All outputs are registered and change on the same edge as the state.
- Timer:
  - Loaded with the interval duration on entry to each state.
  - Decrements on each tick.
  - The state exits on the edge where tick=1 and timer==1, so each state lasts exactly N ticks.
  - A duration input of 0 is treated as 1.
  - Durations are sampled only at load; mid-interval changes do not affect the current interval.
- Request latch: pending[i] is set on any cycle where the request is 1 (or RECALL=1). It is cleared on the edge that grants phase i. A request for phase i arriving on its own grant edge is absorbed and not re-latched.
- ALLRED exit:
  - When the clearance interval has expired and pending≠0, grant the first pending index searching from ptr upward with wrap 4→0.
  - Set ptr=granted+1 mod 5.
  - Go to GREEN for roads (load green_time) or WALK for PL (load walk_time).
- If clearance has expired and pending==0: stay in ALLRED, all RED / PED_STOP, active_phase=7. Grant on the first edge where pending≠0, with no additional clearance.
- GREEN: the granted road shows GREEN, all others RED, pl=PED_STOP. On expiry go to YELLOW (load yellow_time).
- YELLOW: the granted road shows YELLOW. On expiry go to ALLRED (load CLEAR_TICKS) with active_phase=7.
- WALK: all roads RED, pl=PED_GO. On expiry go to ALLRED. Pedestrian has no yellow stage.
- Safety invariant: at most one road is non-RED at any time. pl=PED_GO only when all roads are RED.
- The scheduler does not extend green or pre-empt. Requests for the active phase during its green are absorbed (see request latch).
- Reset mid-interval returns to the reset state immediately, regardless of state.

Decomposition:
- Package traffic_pkg holds:
  - lamp code constants GREEN/YELLOW/RED/PED_GO/PED_STOP;
  - phase index constants PH_P1..PH_PL and PH_NONE=3'd7;
  - the state enum.
- Sub-module rr_arbiter5: 5-request round-robin priority encoder, combinational. Inputs: pending and ptr. Outputs: grant index and valid. The pointer register lives in the parent.

Test Plan:
- Reset release with veh_req=4'b0001, green=3, yellow=1, tick every cycle → ALLRED for 2 ticks, P1 GREEN for exactly 3 ticks, YELLOW for 1 tick, then ALLRED; pending[0] clears on grant.
- RECALL=1, all durations=2 → phase order P1,P2,P3,P4,PL repeating. PL phase shows pl=4'b0000 with all roads 5'b00100. Period = 4·(2+2+2) + (2+2) = 28 ticks.
- Round-robin fairness: hold veh_req=4'b1001 continuously → grants alternate P1,P4,P1,P4; P2 and P3 are never granted.
- ped_req pulse of one cycle during P2 GREEN → pending[4] holds. PL is granted after P2 unless P3/P4 are pending ahead of it in ptr order.
- Zero durations: green_time=0, yellow_time=0 → each interval lasts 1 tick. Changing green_time mid-GREEN does not alter the current interval.
- Assert reset low during YELLOW of P3 → all outputs return to RED/PED_STOP, active_phase=7, pending=0 asynchronously. After release, the first grant follows 2 ticks of ALLRED.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase indices and scheduler state type.
package traffic_pkg;

    localparam int unsigned NUM_PH = 5;

    localparam logic [4:0] GREEN    = 5'b10011;
    localparam logic [4:0] YELLOW   = 5'b01000;
    localparam logic [4:0] RED      = 5'b00100;
    localparam logic [3:0] PED_GO   = 4'b0000;
    localparam logic [3:0] PED_STOP = 4'b1111;

    localparam logic [2:0] PH_P1   = 3'd0;
    localparam logic [2:0] PH_P2   = 3'd1;
    localparam logic [2:0] PH_P3   = 3'd2;
    localparam logic [2:0] PH_P4   = 3'd3;
    localparam logic [2:0] PH_PL   = 3'd4;
    localparam logic [2:0] PH_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_WALK   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin priority encoder; pointer register lives in the parent.
module rr_arbiter5
    import traffic_pkg::*;
(
    input  logic [NUM_PH-1:0] pending,
    input  logic [2:0]        ptr,
    output logic [2:0]        grant,
    output logic              valid
);

    logic [3:0] idx;

    // Scan downward in distance so the pending index nearest to ptr wins last.
    always_comb begin
        grant = PH_NONE;
        valid = 1'b0;
        idx   = '0;
        for (int k = int'(NUM_PH) - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_PH)) begin
                idx = idx - 4'(NUM_PH);
            end
            if (pending[idx[2:0]]) begin
                grant = idx[2:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for four roads plus a pedestrian crossing.
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned CLEAR_TICKS = 2,
    parameter bit          RECALL      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [3:0]         veh_req,
    input  logic               ped_req,
    input  logic [TIMER_W-1:0] green_time,
    input  logic [TIMER_W-1:0] yellow_time,
    input  logic [TIMER_W-1:0] walk_time,
    output logic [4:0]         p1,
    output logic [4:0]         p2,
    output logic [4:0]         p3,
    output logic [4:0]         p4,
    output logic [3:0]         pl,
    output logic [2:0]         active_phase,
    output logic [4:0]         pending
);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         ptr;

    logic [2:0] arb_grant;
    logic       arb_valid;
    logic       expire;
    logic       grant_edge;
    logic [4:0] req_raw;
    logic [4:0] serve_mask;
    logic [4:0] grant_mask;
    logic [4:0] pending_nxt;

    rr_arbiter5 u_arb (
        .pending (pending),
        .ptr     (ptr),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    // A zero duration still occupies one tick.
    function automatic logic [TIMER_W-1:0] load_dur(input logic [TIMER_W-1:0] d);
        return (d == '0) ? TIMER_W'(1) : d;
    endfunction

    // Road lamp vector {p4,p3,p2,p1} with one road showing code, rest RED.
    function automatic logic [19:0] road_lamps(input logic [2:0] ph, input logic [4:0] code);
        logic [19:0] v;
        v = {4{RED}};
        case (ph)
            PH_P1:   v[4:0]   = code;
            PH_P2:   v[9:5]   = code;
            PH_P3:   v[14:10] = code;
            PH_P4:   v[19:15] = code;
            default: v = {4{RED}};
        endcase
        return v;
    endfunction

    // Interval expiry, grant qualification and request latch next value.
    always_comb begin
        expire     = tick && (timer == TIMER_W'(1));
        grant_edge = (state == ST_ALLRED) && arb_valid &&
                     ((timer == '0) || expire);
        req_raw    = RECALL ? 5'b11111 : {ped_req, veh_req};
        serve_mask = '0;
        if ((state == ST_GREEN) || (state == ST_WALK)) begin
            serve_mask = 5'(1) << active_phase;
        end
        grant_mask  = grant_edge ? (5'(1) << arb_grant) : 5'b00000;
        pending_nxt = (pending | (req_raw & ~serve_mask)) & ~grant_mask;
    end

    // Phase FSM with interval timer and registered lamp outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_ALLRED;
            timer        <= TIMER_W'(CLEAR_TICKS);
            ptr          <= '0;
            pending      <= '0;
            {p4, p3, p2, p1} <= {4{RED}};
            pl           <= PED_STOP;
            active_phase <= PH_NONE;
        end else begin
            pending <= pending_nxt;
            case (state)
                ST_ALLRED: begin
                    if (grant_edge) begin
                        active_phase <= arb_grant;
                        ptr          <= (arb_grant == PH_PL) ? 3'd0 : arb_grant + 3'd1;
                        if (arb_grant == PH_PL) begin
                            state <= ST_WALK;
                            timer <= load_dur(walk_time);
                            pl    <= PED_GO;
                        end else begin
                            state <= ST_GREEN;
                            timer <= load_dur(green_time);
                            {p4, p3, p2, p1} <= road_lamps(arb_grant, GREEN);
                        end
                    end else if (tick && (timer != '0)) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_GREEN: begin
                    if (expire) begin
                        state <= ST_YELLOW;
                        timer <= load_dur(yellow_time);
                        {p4, p3, p2, p1} <= road_lamps(active_phase, YELLOW);
                    end else if (tick) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_YELLOW: begin
                    if (expire) begin
                        state        <= ST_ALLRED;
                        timer        <= TIMER_W'(CLEAR_TICKS);
                        active_phase <= PH_NONE;
                        {p4, p3, p2, p1} <= {4{RED}};
                    end else if (tick) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_WALK: begin
                    if (expire) begin
                        state        <= ST_ALLRED;
                        timer        <= TIMER_W'(CLEAR_TICKS);
                        active_phase <= PH_NONE;
                        pl           <= PED_STOP;
                    end else if (tick) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: begin
                    state <= ST_ALLRED;
                    timer <= TIMER_W'(CLEAR_TICKS);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: expected lamp segments are queued, a monitor pops on every output change.
module tb_intersection_phase_scheduler;

    localparam int K_AR = 0;
    localparam int K_G  = 1;
    localparam int K_Y  = 2;
    localparam int K_W  = 3;

    typedef struct {
        logic [26:0] lamps;
        int          dur;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] veh_req = 4'b0000;
    logic       ped_req = 1'b0;
    logic [7:0] green_time = 8'd3;
    logic [7:0] yellow_time = 8'd1;
    logic [7:0] walk_time = 8'd2;
    logic [4:0] p1, p2, p3, p4;
    logic [3:0] pl;
    logic [2:0] active_phase;
    logic [4:0] pending;

    logic [3:0] r_veh = 4'b0000;
    logic       r_ped = 1'b0;
    logic [7:0] r_dur = 8'd2;
    logic [4:0] r_p1, r_p2, r_p3, r_p4;
    logic [3:0] r_pl;
    logic [2:0] r_ap;
    logic [4:0] r_pending;

    logic sel = 1'b0;
    seg_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    intersection_phase_scheduler #(.TIMER_W(8), .CLEAR_TICKS(2), .RECALL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .tick(tick), .veh_req(veh_req), .ped_req(ped_req),
        .green_time(green_time), .yellow_time(yellow_time), .walk_time(walk_time),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .pl(pl),
        .active_phase(active_phase), .pending(pending)
    );

    intersection_phase_scheduler #(.TIMER_W(8), .CLEAR_TICKS(2), .RECALL(1'b1)) u_recall (
        .clk(clk), .reset(reset), .tick(tick), .veh_req(r_veh), .ped_req(r_ped),
        .green_time(r_dur), .yellow_time(r_dur), .walk_time(r_dur),
        .p1(r_p1), .p2(r_p2), .p3(r_p3), .p4(r_p4), .pl(r_pl),
        .active_phase(r_ap), .pending(r_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for one lamp segment, packed as {p1,p2,p3,p4,pl,active_phase}.
    function automatic seg_t mk(input int ph, input int kind, input int dur);
        logic [4:0] r [4];
        logic [3:0] l;
        logic [2:0] a;
        seg_t       s;
        for (int i = 0; i < 4; i++) r[i] = 5'b00100;
        l = 4'b1111;
        a = 3'd7;
        if (kind == K_G) begin
            r[ph] = 5'b10011;
            a = 3'(ph);
        end else if (kind == K_Y) begin
            r[ph] = 5'b01000;
            a = 3'(ph);
        end else if (kind == K_W) begin
            l = 4'b0000;
            a = 3'd4;
        end
        s.lamps = {r[0], r[1], r[2], r[3], l, a};
        s.dur   = dur;
        return s;
    endfunction

    task automatic push(input int ph, input int kind, input int dur);
        q.push_back(mk(ph, kind, dur));
    endtask

    task automatic push_road(input int ph, input int g, input int y, input int c);
        push(ph, K_G, g);
        push(ph, K_Y, y);
        push(0, K_AR, c);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Wait (bounded) for all expected segments, then hold the DUTs in reset.
    task automatic wait_done(input int limit, input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(32'(q.size()), 32'd0, {name, "_drain"});
        reset = 1'b0;
        q.delete();
    endtask

    // Monitor: a change of any lamp/phase output ends one segment and starts the next.
    initial begin
        logic [26:0] obs;
        logic [26:0] last;
        seg_t        cur;
        bit          have;
        int          cnt;
        have = 1'b0;
        cnt = 0;
        last = '0;
        cur = mk(0, K_AR, 0);
        forever begin
            @(negedge clk);
            if (!reset) begin
                have = 1'b0;
                cnt = 0;
            end else begin
                obs = sel ? {r_p1, r_p2, r_p3, r_p4, r_pl, r_ap}
                          : {p1, p2, p3, p4, pl, active_phase};
                if (!have || obs != last) begin
                    if (have && cur.dur != 0) chk(32'(cnt), 32'(cur.dur), "seg_len");
                    chk(32'(q.size() != 0), 32'd1, "seg_available");
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        chk(32'(obs), 32'(cur.lamps), "seg_lamps");
                    end
                    have = 1'b1;
                    last = obs;
                    cnt = 1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        step(2);
        chk(32'({p1, p2, p3, p4}), 32'({4{5'b00100}}), "rst_roads");
        chk(32'(pl), 32'hf, "rst_pl");
        chk(32'(active_phase), 32'd7, "rst_phase");
        chk(32'(pending), 32'd0, "rst_pending");

        // Single P1 request: 2 clearance, 3 green, 1 yellow.
        veh_req = 4'b0001; green_time = 8'd3; yellow_time = 8'd1;
        push(0, K_AR, 2); push_road(0, 3, 1, 0);
        release_rst();
        step(1); veh_req = 4'b0000;
        @(negedge clk); chk(32'(pending), 32'h01, "t1_pending_latched");
        step(1);
        @(negedge clk); chk(32'(pending), 32'h00, "t1_pending_cleared");
        wait_done(40, "t1");

        // RECALL instance: fixed P1..P4,PL cycle, period 28 ticks.
        sel = 1'b1;
        push(0, K_AR, 2);
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 4; r++) push_road(r, 2, 2, 2);
            push(4, K_W, 2);
            push(0, K_AR, (p == 1) ? 0 : 2);
        end
        release_rst();
        wait_done(80, "t2");
        sel = 1'b0;

        // Held P1+P4: grants alternate P1,P4,P1,P4.
        veh_req = 4'b1001; green_time = 8'd2; yellow_time = 8'd1;
        push(0, K_AR, 2);
        for (int i = 0; i < 4; i++) push_road((i % 2 == 0) ? 0 : 3, 2, 1, (i == 3) ? 0 : 2);
        release_rst();
        wait_done(80, "t3");
        veh_req = 4'b0000;

        // Ped + P4 pulse during P2 green: P4 precedes PL in pointer order.
        veh_req = 4'b0010; green_time = 8'd3; yellow_time = 8'd1; walk_time = 8'd2;
        push(0, K_AR, 2); push_road(1, 3, 1, 2); push_road(3, 3, 1, 2);
        push(4, K_W, 2); push(0, K_AR, 0);
        release_rst();
        step(1); veh_req = 4'b0000;
        step(1); ped_req = 1'b1; veh_req = 4'b1000;
        step(1); ped_req = 1'b0; veh_req = 4'b0000;
        @(negedge clk); chk(32'(pending), 32'h18, "t4_pending_held");
        wait_done(60, "t4");

        // Zero durations behave as one tick.
        veh_req = 4'b0001; green_time = 8'd0; yellow_time = 8'd0;
        push(0, K_AR, 2); push_road(0, 1, 1, 0);
        release_rst();
        step(1); veh_req = 4'b0000;
        wait_done(30, "t5a");

        // Green duration changed mid-interval keeps the loaded value.
        veh_req = 4'b0100; green_time = 8'd3; yellow_time = 8'd0;
        push(0, K_AR, 2); push_road(2, 3, 1, 0);
        release_rst();
        step(1); veh_req = 4'b0000;
        step(1); green_time = 8'd10;
        wait_done(40, "t5b");
        green_time = 8'd3;

        // Reset during P3 yellow returns everything to the reset state at once.
        veh_req = 4'b0100; green_time = 8'd2; yellow_time = 8'd3;
        push(0, K_AR, 2); push(2, K_G, 2); push(2, K_Y, 0);
        release_rst();
        step(5);
        chk(32'(q.size()), 32'd0, "t6_in_yellow");
        chk(32'(p3), 32'h08, "t6_p3_yellow");
        reset = 1'b0;
        #1;
        chk(32'({p1, p2, p3, p4}), 32'({4{5'b00100}}), "t6_roads");
        chk(32'(pl), 32'hf, "t6_pl");
        chk(32'(active_phase), 32'd7, "t6_phase");
        chk(32'(pending), 32'd0, "t6_pending");
        q.delete();
        push(0, K_AR, 2); push_road(2, 2, 3, 0);
        release_rst();
        wait_done(40, "t6");
        veh_req = 4'b0000;

        step(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
